shift_deser: RTL and testbench



---
 rtl/shift_deser.sv | 89 ++++++++
 tb/tb_shift_deser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deser.sv
// Serial-in / parallel-out receiver: rebuilds WIDTH-bit words from a SYNC-framed
// bit stream and presents each completed word with a one-cycle VALID pulse.
module shift_deser #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     CLK,
    input  logic                     A_CLR,
    input  logic                     EN,
    input  logic                     SIN,
    input  logic                     SYNC,
    output logic [WIDTH-1:0]         OUT,
    output logic                     VALID,
    output logic                     BUSY,
    output logic                     FRAME_ERR,
    output logic [$clog2(WIDTH)-1:0] BITCNT
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift_c;
    logic [WIDTH-1:0] sr_first_c;

    // Bit order: continuing shift and first-bit-of-frame images of the shift register
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shift_c = {sr[WIDTH-2:0], SIN};
            assign sr_first_c = {{(WIDTH-1){1'b0}}, SIN};
        end else begin : g_lsb_first
            assign sr_shift_c = {SIN, sr[WIDTH-1:1]};
            assign sr_first_c = {SIN, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    assign BUSY = (state == SHIFT);

    // Frame FSM; EN=0 freezes everything and only lets the pulses drop
    always_ff @(posedge CLK or posedge A_CLR) begin
        if (A_CLR) begin
            state     <= IDLE;
            sr        <= '0;
            OUT       <= '0;
            BITCNT    <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (EN) begin
                case (state)
                    IDLE: begin
                        if (SYNC) begin
                            sr     <= sr_first_c;
                            BITCNT <= CW'(1);
                            state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // SYNC wins even over the would-be last bit
                        if (SYNC) begin
                            sr        <= sr_first_c;
                            BITCNT    <= CW'(1);
                            FRAME_ERR <= 1'b1;
                        end else if (BITCNT == LAST_BIT) begin
                            sr     <= sr_shift_c;
                            OUT    <= sr_shift_c;
                            VALID  <= 1'b1;
                            BITCNT <= '0;
                            state  <= IDLE;
                        end else begin
                            sr     <= sr_shift_c;
                            BITCNT <= BITCNT + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: MSB-first and LSB-first instances share one serial stream
// and are compared against a queue-based frame model.
module tb_shift_deser;

    logic        CLK;
    logic        A_CLR;
    logic        EN;
    logic        SIN;
    logic        SYNC;
    logic [15:0] OUT_m,  OUT_l;
    logic        VALID_m, VALID_l;
    logic        BUSY_m, BUSY_l;
    logic        FERR_m, FERR_l;
    logic [3:0]  BITCNT_m, BITCNT_l;

    shift_deser #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .CLK(CLK), .A_CLR(A_CLR), .EN(EN), .SIN(SIN), .SYNC(SYNC),
        .OUT(OUT_m), .VALID(VALID_m), .BUSY(BUSY_m),
        .FRAME_ERR(FERR_m), .BITCNT(BITCNT_m)
    );

    shift_deser #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .A_CLR(A_CLR), .EN(EN), .SIN(SIN), .SYNC(SYNC),
        .OUT(OUT_l), .VALID(VALID_l), .BUSY(BUSY_l),
        .FRAME_ERR(FERR_l), .BITCNT(BITCNT_l)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the frame is a queue of received bits
    bit          frame[$];
    bit          in_frame;
    logic [15:0] exp_out_m, exp_out_l;
    bit          exp_valid, exp_ferr;

    // Observations collected per tick
    int          tick_no;
    int          n_valid_m, n_valid_l, n_ferr_m, n_busy_m;
    int          valid_ticks_l[$];
    logic [15:0] outs_m[$], outs_l[$];

    task automatic clear_obs();
        n_valid_m = 0; n_valid_l = 0; n_ferr_m = 0; n_busy_m = 0;
        valid_ticks_l.delete(); outs_m.delete(); outs_l.delete();
    endtask

    // One clock edge: drive at negedge, update model, observe at next negedge
    task automatic tick(input bit en, input bit sync, input bit sin);
        EN = en; SYNC = sync; SIN = sin;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        if (en) begin
            if (sync) begin
                exp_ferr = in_frame;
                frame.delete();
                frame.push_back(sin);
                in_frame = 1'b1;
            end else if (in_frame) begin
                frame.push_back(sin);
                if (frame.size() == 16) begin
                    for (int i = 0; i < 16; i++) begin
                        exp_out_m[15-i] = frame[i];
                        exp_out_l[i]    = frame[i];
                    end
                    exp_valid = 1'b1;
                    in_frame  = 1'b0;
                    frame.delete();
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        tick_no++;
        if (VALID_m) begin n_valid_m++; outs_m.push_back(OUT_m); end
        if (VALID_l) begin n_valid_l++; outs_l.push_back(OUT_l); valid_ticks_l.push_back(tick_no); end
        if (FERR_m) n_ferr_m++;
        if (BUSY_m) n_busy_m++;
    endtask

    // Bit i of word w in transmit order (MSB-first or LSB-first)
    function automatic bit word_bit(input logic [15:0] w, input bit lsb, input int i);
        return lsb ? w[i] : w[15-i];
    endfunction

    task automatic send_range(input logic [15:0] w, input bit lsb, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) tick(1'b1, i == 0, word_bit(w, lsb, i));
    endtask

    task automatic model_reset();
        frame.delete();
        in_frame  = 1'b0;
        exp_out_m = '0;
        exp_out_l = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        EN = 1'b0; SYNC = 1'b0; SIN = 1'b0;
        A_CLR = 1'b1;
        model_reset();
        #2;
        A_CLR = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (OUT_m !== 16'h0 || OUT_l !== 16'h0) begin
            n_err++; $display("FAIL reset_out: got %h/%h want 0000/0000", OUT_m, OUT_l);
        end
        n_cmp++;
        if ({VALID_m, BUSY_m, FERR_m, VALID_l, BUSY_l, FERR_l} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000",
                              {VALID_m, BUSY_m, FERR_m, VALID_l, BUSY_l, FERR_l});
        end
        n_cmp++;
        if (BITCNT_m !== 4'd0 || BITCNT_l !== 4'd0) begin
            n_err++; $display("FAIL reset_bitcnt: got %0d/%0d want 0/0", BITCNT_m, BITCNT_l);
        end
    endtask

    task automatic test_basic();
        clear_obs();
        send_range(16'hA5C3, 1'b0, 0, 15);
        n_cmp++;
        if (n_valid_m != 1) begin
            n_err++; $display("FAIL basic_valid_count: got %0d want 1", n_valid_m);
        end
        n_cmp++;
        if (OUT_m !== 16'hA5C3) begin
            n_err++; $display("FAIL basic_out: got %h want a5c3", OUT_m);
        end
        n_cmp++;
        if (n_busy_m != 15) begin
            n_err++; $display("FAIL basic_busy_cycles: got %0d want 15", n_busy_m);
        end
        n_cmp++;
        if (BUSY_m !== 1'b0 || VALID_m !== 1'b1) begin
            n_err++; $display("FAIL basic_valid_busy: got valid=%b busy=%b want 1/0", VALID_m, BUSY_m);
        end
    endtask

    task automatic test_en_gaps();
        int start_tick;
        clear_obs();
        start_tick = tick_no;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, i == 0, word_bit(16'hA5C3, 1'b0, i));
            if (i == 3 || i == 10) begin
                for (int g = 0; g < 2; g++) begin
                    tick(1'b0, 1'b0, 1'($urandom));
                    n_cmp++;
                    if (BITCNT_m !== 4'(i + 1) || VALID_m !== 1'b0) begin
                        n_err++; $display("FAIL gap_freeze: bitcnt=%0d valid=%b want %0d/0", BITCNT_m, VALID_m, i + 1);
                    end
                end
            end
        end
        n_cmp++;
        if (VALID_m !== 1'b1 || OUT_m !== 16'hA5C3 || tick_no - start_tick != 20) begin
            n_err++; $display("FAIL gap_result: valid=%b out=%h ticks=%0d want 1/a5c3/20",
                              VALID_m, OUT_m, tick_no - start_tick);
        end
    endtask

    task automatic test_resync();
        clear_obs();
        send_range(16'h1234, 1'b0, 0, 6);
        send_range(16'hBEEF, 1'b0, 0, 15);
        n_cmp++;
        if (n_ferr_m != 1) begin
            n_err++; $display("FAIL resync_ferr_count: got %0d want 1", n_ferr_m);
        end
        n_cmp++;
        if (n_valid_m != 1 || OUT_m !== 16'hBEEF) begin
            n_err++; $display("FAIL resync_out: valids=%0d out=%h want 1/beef", n_valid_m, OUT_m);
        end
    endtask

    task automatic test_clear();
        clear_obs();
        send_range(16'h00FF, 1'b0, 0, 15);
        n_cmp++;
        if (OUT_m !== 16'h00FF) begin
            n_err++; $display("FAIL clear_pre_out: got %h want 00ff", OUT_m);
        end
        send_range(16'hFFFF, 1'b0, 0, 8);
        A_CLR = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (OUT_m !== 16'h0 || BUSY_m !== 1'b0 || BITCNT_m !== 4'd0) begin
            n_err++; $display("FAIL clear_immediate: out=%h busy=%b bitcnt=%0d want 0000/0/0", OUT_m, BUSY_m, BITCNT_m);
        end
        #2;
        A_CLR = 1'b0;
        @(negedge CLK);
        clear_obs();
        send_range(16'h5A5A, 1'b0, 0, 15);
        n_cmp++;
        if (n_valid_m != 1 || OUT_m !== 16'h5A5A) begin
            n_err++; $display("FAIL clear_next_frame: valids=%0d out=%h want 1/5a5a", n_valid_m, OUT_m);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_range(16'h0001, 1'b1, 0, 15);
        send_range(16'h8000, 1'b1, 0, 15);
        n_cmp++;
        if (valid_ticks_l.size() != 2) begin
            n_err++; $display("FAIL b2b_count: got %0d want 2", valid_ticks_l.size());
        end else begin
            n_cmp++;
            if (valid_ticks_l[1] - valid_ticks_l[0] != 16) begin
                n_err++; $display("FAIL b2b_spacing: got %0d want 16", valid_ticks_l[1] - valid_ticks_l[0]);
            end
            n_cmp++;
            if (outs_l[0] !== 16'h0001 || outs_l[1] !== 16'h8000) begin
                n_err++; $display("FAIL b2b_words: got %h,%h want 0001,8000", outs_l[0], outs_l[1]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [15:0] din;
        for (int k = 0; k < 6; k++) begin
            din = 16'($urandom_range(0, 512));
            clear_obs();
            send_range(din, 1'b0, 0, 15);
            n_cmp++;
            if (n_valid_m != 1 || OUT_m !== din) begin
                n_err++; $display("FAIL loopback: valids=%0d out=%h want 1/%h", n_valid_m, OUT_m, din);
            end
        end
    endtask

    task automatic test_random();
        bit en, sync;
        for (int c = 0; c < 600; c++) begin
            en   = ($urandom % 4) != 0;
            sync = in_frame ? (($urandom % 24) == 0) : (($urandom % 3) == 0);
            tick(en, sync, 1'($urandom));
            n_cmp++;
            if (OUT_m !== exp_out_m || OUT_l !== exp_out_l) begin
                n_err++; $display("FAIL rand_out c=%0d: got %h/%h want %h/%h", c, OUT_m, OUT_l, exp_out_m, exp_out_l);
            end
            n_cmp++;
            if ({VALID_m, FERR_m, BUSY_m} !== {exp_valid, exp_ferr, in_frame} ||
                {VALID_l, FERR_l, BUSY_l} !== {exp_valid, exp_ferr, in_frame}) begin
                n_err++; $display("FAIL rand_flags c=%0d: got %b/%b want %b", c,
                                  {VALID_m, FERR_m, BUSY_m}, {VALID_l, FERR_l, BUSY_l},
                                  {exp_valid, exp_ferr, in_frame});
            end
            n_cmp++;
            if (BITCNT_m !== 4'(frame.size()) || BITCNT_l !== 4'(frame.size())) begin
                n_err++; $display("FAIL rand_bitcnt c=%0d: got %0d/%0d want %0d", c, BITCNT_m, BITCNT_l, frame.size());
            end
        end
    endtask

    initial begin
        A_CLR = 1'b1; EN = 1'b0; SYNC = 1'b0; SIN = 1'b0;
        tick_no = 0;
        model_reset();
        clear_obs();
        test_reset();
        test_basic();
        test_en_gaps();
        test_resync();
        test_clear();
        test_back_to_back();
        test_loopback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
